// File: rtl/demux_dispatch4.sv
`default_nettype none
// ============================================================================
//  Module   : demux_dispatch4
//  Purpose  : Serial dispatcher that writes one latched source word into up
//             to four destination holding registers, one per cycle, in
//             ascending index order. It is the inverse of the 4-input word mux.
//  Ports    : clk, reset         - rising-edge clock, synchronous active-high reset
//             req, mask, data_in - request, target set and word (sampled in IDLE)
//             busy, done         - dispatch in progress / pulse on final write
//             wr_en, sel_out     - one-hot strobe and binary index of current write
//             data_out           - latched dispatch word
//             reg_0..reg_3       - destination holding registers
//  Revision : 1.0  initial release
// ============================================================================
module demux_dispatch4 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [3:0]       mask,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [3:0]       wr_en,
  output logic [2:0]       sel_out,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] reg_0,
  output logic [WIDTH-1:0] reg_1,
  output logic [WIDTH-1:0] reg_2,
  output logic [WIDTH-1:0] reg_3
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_DISPATCH = 1'b1;

  logic [0:0]       state_q,    state_d;
  logic [3:0]       pending_q,  pending_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] regs_q [4];
  logic [WIDTH-1:0] regs_d [4];

  logic [1:0]       low_idx;
  logic             last_one;

  // Lowest set bit of pending selects the destination for this cycle.
  always_comb begin
    low_idx = 2'd0;
    casez (pending_q)
      4'b???1: low_idx = 2'd0;
      4'b??10: low_idx = 2'd1;
      4'b?100: low_idx = 2'd2;
      4'b1000: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
  end

  // Exactly one bit left: clearing the lowest bit leaves nothing.
  assign last_one = (pending_q != 4'b0000) &&
                    ((pending_q & (pending_q - 4'd1)) == 4'b0000);

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= 4'b0000;
      data_out_q <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      data_out_q <= data_out_d;
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    data_out_d = data_out_q;
    for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
    case (state_q)
      ST_IDLE: begin
        // An empty mask is a no-op request.
        if (req && (mask != 4'b0000)) begin
          pending_d  = mask;
          data_out_d = data_in;
          state_d    = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        regs_d[low_idx]    = data_out_q;
        pending_d[low_idx] = 1'b0;
        if (last_one) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    wr_en   = 4'b0000;
    sel_out = 3'b000;
    if (state_q == ST_DISPATCH) begin
      busy    = 1'b1;
      done    = last_one;
      wr_en   = 4'b0001 << low_idx;
      sel_out = {1'b0, low_idx};
    end
  end

  assign data_out = data_out_q;
  assign reg_0    = regs_q[0];
  assign reg_1    = regs_q[1];
  assign reg_2    = regs_q[2];
  assign reg_3    = regs_q[3];

endmodule
`default_nettype wire

// File: tb/tb_demux_dispatch4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_dispatch4
//  Purpose  : Directed self-checking bench for demux_dispatch4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_dispatch4;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             req;
  logic [3:0]       mask;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [3:0]       wr_en;
  logic [2:0]       sel_out;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] reg_0, reg_1, reg_2, reg_3;

  int n_cmp = 0;
  int n_err = 0;

  demux_dispatch4 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .mask     (mask),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .wr_en    (wr_en),
    .sel_out  (sel_out),
    .data_out (data_out),
    .reg_0    (reg_0),
    .reg_1    (reg_1),
    .reg_2    (reg_2),
    .reg_3    (reg_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
    check({tag, ".reg_0"}, reg_0, e0);
    check({tag, ".reg_1"}, reg_1, e1);
    check({tag, ".reg_2"}, reg_2, e2);
    check({tag, ".reg_3"}, reg_3, e3);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; mask = 4'b0000; data_in = '0;
    tick(); tick();
    check("rst.busy", {31'b0, busy}, 32'd0);
    check("rst.done", {31'b0, done}, 32'd0);
    check("rst.wr_en", {28'b0, wr_en}, 32'd0);
    check("rst.sel", {29'b0, sel_out}, 32'd0);
    check("rst.data_out", data_out, 32'd0);
    check_regs("rst", 32'd0, 32'd0, 32'd0, 32'd0);
    reset = 1'b0;

    // 1: single target
    req = 1'b1; mask = 4'b0100; data_in = 32'hDEADBEEF;
    tick();
    req = 1'b0;
    check("t1.wr_en", {28'b0, wr_en}, 32'h4);
    check("t1.sel", {29'b0, sel_out}, 32'd2);
    check("t1.done", {31'b0, done}, 32'd1);
    check("t1.busy", {31'b0, busy}, 32'd1);
    tick();
    check("t1.busy_end", {31'b0, busy}, 32'd0);
    check("t1.data_out", data_out, 32'hDEADBEEF);
    check_regs("t1", 32'd0, 32'd0, 32'hDEADBEEF, 32'd0);

    // 2: mask 1011
    req = 1'b1; mask = 4'b1011; data_in = 32'h5;
    tick();
    req = 1'b0;
    check("t2.c1.wr_en", {28'b0, wr_en}, 32'h1);
    check("t2.c1.sel", {29'b0, sel_out}, 32'd0);
    check("t2.c1.done", {31'b0, done}, 32'd0);
    tick();
    check("t2.c2.wr_en", {28'b0, wr_en}, 32'h2);
    check("t2.c2.sel", {29'b0, sel_out}, 32'd1);
    check("t2.c2.done", {31'b0, done}, 32'd0);
    tick();
    check("t2.c3.wr_en", {28'b0, wr_en}, 32'h8);
    check("t2.c3.sel", {29'b0, sel_out}, 32'd3);
    check("t2.c3.done", {31'b0, done}, 32'd1);
    tick();
    check("t2.busy_end", {31'b0, busy}, 32'd0);
    check_regs("t2", 32'h5, 32'h5, 32'hDEADBEEF, 32'h5);

    // 3: empty mask is ignored
    req = 1'b1; mask = 4'b0000; data_in = 32'h77;
    tick();
    check("t3.busy", {31'b0, busy}, 32'd0);
    check("t3.done", {31'b0, done}, 32'd0);
    check("t3.wr_en", {28'b0, wr_en}, 32'd0);
    tick();
    check("t3.busy2", {31'b0, busy}, 32'd0);
    check("t3.data_out", data_out, 32'h5);
    req = 1'b0;

    // 4: full mask, new req during dispatch ignored, held req accepted after
    req = 1'b1; mask = 4'b1111; data_in = 32'hA5A5A5A5;
    tick();
    data_in = 32'h12345678;
    check("t4.c1.wr_en", {28'b0, wr_en}, 32'h1);
    tick();
    check("t4.c2.wr_en", {28'b0, wr_en}, 32'h2);
    check("t4.c2.data_out", data_out, 32'hA5A5A5A5);
    tick();
    check("t4.c3.sel", {29'b0, sel_out}, 32'd2);
    tick();
    check("t4.c4.sel", {29'b0, sel_out}, 32'd3);
    check("t4.c4.done", {31'b0, done}, 32'd1);
    tick();
    check("t4.idle.busy", {31'b0, busy}, 32'd0);
    check_regs("t4a", 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
    tick();
    req = 1'b0;
    check("t4.re.busy", {31'b0, busy}, 32'd1);
    check("t4.re.data_out", data_out, 32'h12345678);
    check("t4.re.wr_en", {28'b0, wr_en}, 32'h1);
    tick(); tick(); tick(); tick();
    check("t4.re.busy_end", {31'b0, busy}, 32'd0);
    check_regs("t4b", 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);

    // 5: reset mid-dispatch
    req = 1'b1; mask = 4'b1111; data_in = 32'hFFFFFFFF;
    tick();
    req = 1'b0;
    tick();
    check("t5.pre.reg_0", reg_0, 32'hFFFFFFFF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5.busy", {31'b0, busy}, 32'd0);
    check("t5.wr_en", {28'b0, wr_en}, 32'd0);
    check("t5.sel", {29'b0, sel_out}, 32'd0);
    check("t5.done", {31'b0, done}, 32'd0);
    check_regs("t5", 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    check("t5.stay_idle", {31'b0, busy}, 32'd0);

    // 6: back-to-back with req held
    req = 1'b1; mask = 4'b0001; data_in = 32'h1;
    tick();
    mask = 4'b1000; data_in = 32'h2;
    check("t6.a.wr_en", {28'b0, wr_en}, 32'h1);
    check("t6.a.done", {31'b0, done}, 32'd1);
    tick();
    check("t6.gap.busy", {31'b0, busy}, 32'd0);
    tick();
    req = 1'b0;
    check("t6.b.busy", {31'b0, busy}, 32'd1);
    check("t6.b.wr_en", {28'b0, wr_en}, 32'h8);
    check("t6.b.sel", {29'b0, sel_out}, 32'd3);
    tick();
    check("t6.busy_end", {31'b0, busy}, 32'd0);
    check_regs("t6", 32'h1, 32'd0, 32'd0, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
